// File: rtl/pixel_word_packer.sv
// pixel_word_packer: gathers DVI pixels into BANDWIDTH-wide RAM words,
// one pixel per BLOCK_WIDTH slot, and produces the bank write address/strobe.
// Frames restart on a vsync rising edge. Partial words are flushed at line end.
// Writes stop once the last bank word has been written.
module pixel_word_packer #(
  parameter int BLOCK_COUNT = 4,
  parameter int BLOCK_WIDTH = 32,
  parameter int BANDWIDTH   = BLOCK_COUNT * BLOCK_WIDTH,
  parameter int PIXEL_WIDTH = 24,
  parameter int DEPTH       = 1024,
  parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                   I_clk,
  input  logic                   I_rst,
  input  logic                   I_vsync,
  input  logic                   I_de,
  input  logic [PIXEL_WIDTH-1:0] I_pixel,
  output logic [BANDWIDTH-1:0]   O_data,
  output logic [ADDR_WIDTH-1:0]  O_addr,
  output logic                   O_we,
  output logic                   O_frame_start,
  output logic                   O_overflow
);

  localparam int SLOT_WIDTH = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1;
  localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(BLOCK_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t                 state, next_state;
  logic [SLOT_WIDTH-1:0]  slot, next_slot, eff_slot;
  logic [ADDR_WIDTH-1:0]  addr, next_addr, eff_addr;
  logic [BANDWIDTH-1:0]   buffer, next_buffer, eff_buffer;
  logic [BANDWIDTH-1:0]   word, write_data, next_data;
  logic [ADDR_WIDTH-1:0]  next_out_addr;
  logic                   next_we, next_frame_start, next_overflow;
  logic                   prev_vsync, prev_de;
  logic                   frame_start, accepting, write;
  logic [BLOCK_WIDTH-1:0] pixel_ext;

  assign frame_start = I_vsync & ~prev_vsync;
  assign pixel_ext   = BLOCK_WIDTH'(I_pixel);

  // Register the FSM state, datapath state and all outputs; reset is synchronous.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state         <= IDLE;
      slot          <= '0;
      addr          <= '0;
      buffer        <= '0;
      prev_vsync    <= 1'b0;
      prev_de       <= 1'b0;
      O_data        <= '0;
      O_addr        <= '0;
      O_we          <= 1'b0;
      O_frame_start <= 1'b0;
      O_overflow    <= 1'b0;
    end else begin
      state         <= next_state;
      slot          <= next_slot;
      addr          <= next_addr;
      buffer        <= next_buffer;
      prev_vsync    <= I_vsync;
      prev_de       <= I_de;
      O_data        <= next_data;
      O_addr        <= next_out_addr;
      O_we          <= next_we;
      O_frame_start <= next_frame_start;
      O_overflow    <= next_overflow;
    end
  end

  // Next-state and write decision. A frame start rewinds slot/address first, so a pixel
  // arriving with the vsync edge lands in slot 0 of the new frame and a pending
  // partial word is dropped rather than flushed.
  always_comb begin
    next_state       = state;
    next_slot        = slot;
    next_addr        = addr;
    next_buffer      = buffer;
    next_data        = O_data;
    next_out_addr    = O_addr;
    next_we          = 1'b0;
    next_frame_start = 1'b0;
    next_overflow    = O_overflow;
    eff_slot         = slot;
    eff_addr         = addr;
    eff_buffer       = buffer;
    accepting        = (state == ACTIVE);
    write            = 1'b0;
    write_data       = '0;
    word             = '0;

    if (frame_start) begin
      next_state       = ACTIVE;
      eff_slot         = '0;
      eff_addr         = '0;
      eff_buffer       = '0;
      next_slot        = '0;
      next_addr        = '0;
      next_buffer      = '0;
      next_overflow    = 1'b0;
      next_frame_start = 1'b1;
      accepting        = 1'b1;
    end

    if (accepting) begin
      if (I_de) begin
        word = eff_buffer;
        for (int k = 0; k < BLOCK_COUNT; k++) begin
          if (eff_slot == SLOT_WIDTH'(k)) word[k*BLOCK_WIDTH +: BLOCK_WIDTH] = pixel_ext;
        end
        if (eff_slot == LAST_SLOT) begin
          write       = 1'b1;
          write_data  = word;
          next_buffer = '0;
          next_slot   = '0;
        end else begin
          next_buffer = word;
          next_slot   = eff_slot + 1'b1;
        end
      end else if (prev_de && (eff_slot != '0)) begin
        write       = 1'b1;
        write_data  = eff_buffer;
        next_buffer = '0;
        next_slot   = '0;
      end

      if (write) begin
        next_we       = 1'b1;
        next_data     = write_data;
        next_out_addr = eff_addr;
        if (eff_addr == LAST_ADDR) begin
          next_state    = FULL;
          next_overflow = 1'b1;
        end else begin
          next_addr = eff_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_word_packer.sv
// tb_pixel_word_packer: directed test of pixel_word_packer with hand-computed words.
// A second instance with DEPTH=4 shares the stimulus to exercise the bank-full path.
module tb_pixel_word_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         vsync = 1'b0;
  logic         de = 1'b0;
  logic [23:0]  pixel = '0;

  logic [127:0] data_big, data_small;
  logic [9:0]   addr_big;
  logic [1:0]   addr_small;
  logic         we_big, we_small, fs_big, fs_small, ovf_big, ovf_small;

  int checks = 0;
  int errors = 0;
  int we_big_count = 0;
  int we_small_count = 0;
  int fs_big_count = 0;

  pixel_word_packer dut (
    .I_clk(clk), .I_rst(rst), .I_vsync(vsync), .I_de(de), .I_pixel(pixel),
    .O_data(data_big), .O_addr(addr_big), .O_we(we_big),
    .O_frame_start(fs_big), .O_overflow(ovf_big)
  );

  pixel_word_packer #(.DEPTH(4)) dut_small (
    .I_clk(clk), .I_rst(rst), .I_vsync(vsync), .I_de(de), .I_pixel(pixel),
    .O_data(data_small), .O_addr(addr_small), .O_we(we_small),
    .O_frame_start(fs_small), .O_overflow(ovf_small)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Drives one cycle of input, then returns at the following falling edge with the
  // outputs produced by that cycle, tallying write strobes and frame-start pulses.
  task automatic applyStimulus(input logic v, input logic d, input logic [23:0] p);
    vsync = v;
    de    = d;
    pixel = p;
    @(posedge clk);
    @(negedge clk);
    if (we_big) we_big_count++;
    if (we_small) we_small_count++;
    if (fs_big) fs_big_count++;
  endtask

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  initial begin
    @(negedge clk);

    // Reset values.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b0, 24'h0);
    rst = 1'b0;
    checkOutput("reset_data", data_big, 128'h0);
    checkOutput("reset_addr", 128'(addr_big), 128'h0);
    checkOutput("reset_we", 128'(we_big), 128'h0);
    checkOutput("reset_fs", 128'(fs_big), 128'h0);
    checkOutput("reset_ovf", 128'(ovf_big), 128'h0);

    // Pixels before any vsync are ignored.
    for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b1, 24'(i));
    applyStimulus(1'b0, 1'b0, 24'h0);
    checkOutput("idle_we_count", 128'(we_big_count), 128'h0);
    checkOutput("idle_addr", 128'(addr_big), 128'h0);

    // Full-rate frame of 8 pixels.
    we_big_count = 0;
    fs_big_count = 0;
    applyStimulus(1'b1, 1'b0, 24'h0);
    checkOutput("fs_pulse", 128'(fs_big), 128'h1);
    applyStimulus(1'b0, 1'b0, 24'h0);
    checkOutput("fs_one_cycle", 128'(fs_big), 128'h0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b1, 24'(i));
      if (i == 4) begin
        checkOutput("word0_we", 128'(we_big), 128'h1);
        checkOutput("word0_addr", 128'(addr_big), 128'h0);
        checkOutput("word0_data", data_big, 128'h00000004_00000003_00000002_00000001);
      end
      if (i == 5) checkOutput("mid_word_we", 128'(we_big), 128'h0);
      if (i == 6) checkOutput("addr_held", 128'(addr_big), 128'h0);
      if (i == 8) begin
        checkOutput("word1_we", 128'(we_big), 128'h1);
        checkOutput("word1_addr", 128'(addr_big), 128'h1);
        checkOutput("word1_data", data_big, 128'h00000008_00000007_00000006_00000005);
      end
    end
    applyStimulus(1'b0, 1'b0, 24'h0);
    checkOutput("no_flush_when_aligned", 128'(we_big), 128'h0);
    applyStimulus(1'b0, 1'b0, 24'h0);
    checkOutput("frame1_we_count", 128'(we_big_count), 128'h2);
    checkOutput("frame1_fs_count", 128'(fs_big_count), 128'h1);

    // Line of 6 pixels flushes a half-filled word when de falls.
    applyStimulus(1'b1, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b0, 24'h0);
    for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b1, 24'(i));
    checkOutput("flush_not_early", 128'(we_big), 128'h0);
    applyStimulus(1'b0, 1'b0, 24'h0);
    checkOutput("flush_we", 128'(we_big), 128'h1);
    checkOutput("flush_addr", 128'(addr_big), 128'h1);
    checkOutput("flush_data", data_big, 128'h00000000_00000000_00000006_00000005);
    applyStimulus(1'b0, 1'b0, 24'h0);
    checkOutput("flush_one_cycle", 128'(we_big), 128'h0);

    // DEPTH=4 instance: 20 pixels fill the bank, the addr-3 write raises overflow.
    applyStimulus(1'b1, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b0, 24'h0);
    we_small_count = 0;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, 1'b1, 24'(i));
      if (i == 12) checkOutput("small_no_ovf_yet", 128'(ovf_small), 128'h0);
      if (i == 16) begin
        checkOutput("small_last_we", 128'(we_small), 128'h1);
        checkOutput("small_last_addr", 128'(addr_small), 128'h3);
        checkOutput("small_last_data", data_small, 128'h00000010_0000000f_0000000e_0000000d);
        checkOutput("small_ovf_rise", 128'(ovf_small), 128'h1);
      end
    end
    applyStimulus(1'b0, 1'b1, 24'h15);
    applyStimulus(1'b0, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b0, 24'h0);
    checkOutput("small_we_count", 128'(we_small_count), 128'h4);
    checkOutput("small_addr_stuck", 128'(addr_small), 128'h3);
    checkOutput("small_ovf_sticky", 128'(ovf_small), 128'h1);
    applyStimulus(1'b1, 1'b0, 24'h0);
    checkOutput("small_ovf_cleared", 128'(ovf_small), 128'h0);
    for (int i = 21; i <= 24; i++) applyStimulus(1'b0, 1'b1, 24'(i));
    checkOutput("small_restart_we", 128'(we_small), 128'h1);
    checkOutput("small_restart_addr", 128'(addr_small), 128'h0);
    checkOutput("small_restart_data", data_small, 128'h00000018_00000017_00000016_00000015);
    applyStimulus(1'b0, 1'b0, 24'h0);

    // Partial word pending at a frame start is discarded, not flushed.
    applyStimulus(1'b0, 1'b1, 24'h1);
    applyStimulus(1'b0, 1'b1, 24'h2);
    we_big_count = 0;
    applyStimulus(1'b1, 1'b0, 24'h0);
    checkOutput("discard_no_we", 128'(we_big), 128'h0);
    for (int i = 9; i <= 12; i++) applyStimulus(1'b0, 1'b1, 24'(i));
    checkOutput("discard_we", 128'(we_big), 128'h1);
    checkOutput("discard_addr", 128'(addr_big), 128'h0);
    checkOutput("discard_data", data_big, 128'h0000000c_0000000b_0000000a_00000009);
    checkOutput("discard_we_count", 128'(we_big_count), 128'h1);
    applyStimulus(1'b0, 1'b0, 24'h0);

    // Vsync edge coincident with a valid pixel: that pixel is slot 0 of the new frame.
    applyStimulus(1'b1, 1'b1, 24'h21);
    for (int i = 34; i <= 36; i++) applyStimulus(1'b0, 1'b1, 24'(i));
    checkOutput("coincident_addr", 128'(addr_big), 128'h0);
    checkOutput("coincident_data", data_big, 128'h00000024_00000023_00000022_00000021);
    applyStimulus(1'b0, 1'b0, 24'h0);

    // Reset mid-line drops pending pixels and returns to idle.
    applyStimulus(1'b1, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b1, 24'h1);
    applyStimulus(1'b0, 1'b1, 24'h2);
    applyStimulus(1'b0, 1'b1, 24'h3);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 24'h4);
    rst = 1'b0;
    checkOutput("midreset_data", data_big, 128'h0);
    checkOutput("midreset_addr", 128'(addr_big), 128'h0);
    checkOutput("midreset_we", 128'(we_big), 128'h0);
    we_big_count = 0;
    applyStimulus(1'b0, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b0, 24'h0);
    checkOutput("midreset_no_flush", 128'(we_big_count), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
